// File: rtl/ovc_credit_status_tracker_if.sv
// Bundle of per-VC control and status signals between the VC/switch allocator
// and one output port's credit/status tracker.
interface ovc_credit_status_tracker_if #(
  parameter int V       = 4,
  parameter int CREDITw = 5
);
  logic [V*CREDITw-1:0] credit_init_val;
  logic [V-1:0]         credit_release_en;
  logic [V-1:0]         credit_in;
  logic [V-1:0]         buff_space_decreased;
  logic [V-1:0]         ovc_is_allocated;
  logic [V-1:0]         ovc_is_released;
  logic [V*CREDITw-1:0] ovc_credit;
  logic [V-1:0]         ovc_full;
  logic [V-1:0]         ovc_nearly_full;
  logic [V-1:0]         ovc_empty;
  logic [V-1:0]         ovc_status;
  logic [V-1:0]         ovc_avalable;
  logic [V-1:0]         credit_err;

  modport master (
    output credit_init_val, credit_release_en, credit_in, buff_space_decreased,
           ovc_is_allocated, ovc_is_released,
    input  ovc_credit, ovc_full, ovc_nearly_full, ovc_empty, ovc_status,
           ovc_avalable, credit_err
  );

  modport slave (
    input  credit_init_val, credit_release_en, credit_in, buff_space_decreased,
           ovc_is_allocated, ovc_is_released,
    output ovc_credit, ovc_full, ovc_nearly_full, ovc_empty, ovc_status,
           ovc_avalable, credit_err
  );
endinterface

// File: rtl/ovc_credit_status_tracker.sv
// Per-output-VC credit counter and allocation FSM for one router output port;
// all status vectors are registered and reflect post-event (next-state) values.
module ovc_credit_status_tracker #(
  parameter int V              = 4,
  parameter int B              = 4,
  parameter int LB             = 16,
  parameter int OVC_ALLOC_MODE = 0,
  localparam int CREDITw       = $clog2(((B > LB) ? B : LB) + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  ovc_credit_status_tracker_if.slave   bus
);

  localparam logic [CREDITw-1:0] B_C    = CREDITw'(B);
  localparam logic [CREDITw-1:0] LB_C   = CREDITw'(LB);
  localparam logic [CREDITw-1:0] ZERO_C = CREDITw'(0);
  localparam logic [CREDITw-1:0] ONE_C  = CREDITw'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A zero init value means the neighbour did not advertise a depth.
  function automatic logic [CREDITw-1:0] init_depth(input logic [CREDITw-1:0] init);
    logic [CREDITw-1:0] d;
    if (init == ZERO_C) begin
      d = B_C;
    end else if (init > LB_C) begin
      d = LB_C;
    end else begin
      d = init;
    end
    return d;
  endfunction

  logic [V-1:0][CREDITw-1:0] depth_q;
  logic [V-1:0][CREDITw-1:0] credit_q;
  logic [V-1:0][CREDITw-1:0] credit_d;
  logic [V-1:0][CREDITw-1:0] rst_depth_s;
  state_t                    state_q [V];
  state_t                    state_d [V];
  logic [V-1:0]              err_q, err_d;
  logic [V-1:0]              full_q, full_d;
  logic [V-1:0]              nearly_q, nearly_d;
  logic [V-1:0]              empty_q, empty_d;
  logic [V-1:0]              status_q, status_d;
  logic [V-1:0]              avail_q, avail_d;
  logic [V-1:0]              rst_nearly_s;
  logic [V-1:0]              rst_avail_s;

  always_comb begin
    credit_d     = credit_q;
    rst_depth_s  = '0;
    err_d        = err_q;
    full_d       = '0;
    nearly_d     = '0;
    empty_d      = '0;
    status_d     = '0;
    avail_d      = '0;
    rst_nearly_s = '0;
    rst_avail_s  = '0;
    for (int v = 0; v < V; v++) begin
      state_d[v]     = state_q[v];
      rst_depth_s[v] = init_depth(bus.credit_init_val[v*CREDITw +: CREDITw]);

      // Credit arithmetic with saturation at both ends; overflow/underflow is a protocol error.
      if (bus.credit_in[v] && bus.buff_space_decreased[v]) begin
        credit_d[v] = credit_q[v];
      end else if (bus.credit_in[v]) begin
        if (credit_q[v] == depth_q[v]) begin
          err_d[v] = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + ONE_C;
        end
      end else if (bus.buff_space_decreased[v]) begin
        if (credit_q[v] == ZERO_C) begin
          err_d[v] = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] - ONE_C;
        end
      end else begin
        credit_d[v] = credit_q[v];
      end

      case (state_q[v])
        ST_IDLE: begin
          if (bus.ovc_is_released[v]) begin
            err_d[v] = 1'b1;
          end else begin
            err_d[v] = err_d[v];
          end
          if (bus.ovc_is_allocated[v]) begin
            state_d[v] = ST_ALLOC;
          end else begin
            state_d[v] = ST_IDLE;
          end
        end
        ST_ALLOC: begin
          if (bus.ovc_is_released[v] && bus.credit_release_en[v]) begin
            // Back-to-back reuse: a same-cycle allocation keeps the OVC owned.
            state_d[v] = bus.ovc_is_allocated[v] ? ST_ALLOC : ST_IDLE;
          end else if (bus.ovc_is_released[v]) begin
            err_d[v]   = err_d[v] | bus.ovc_is_allocated[v];
            state_d[v] = (credit_d[v] == depth_q[v]) ? ST_IDLE : ST_DRAIN;
          end else begin
            err_d[v]   = err_d[v] | bus.ovc_is_allocated[v];
            state_d[v] = ST_ALLOC;
          end
        end
        ST_DRAIN: begin
          err_d[v]   = err_d[v] | bus.ovc_is_allocated[v];
          state_d[v] = (credit_d[v] == depth_q[v]) ? ST_IDLE : ST_DRAIN;
        end
        default: begin
          state_d[v] = ST_IDLE;
        end
      endcase

      full_d[v]       = (credit_d[v] == ZERO_C);
      nearly_d[v]     = (credit_d[v] <= ONE_C);
      empty_d[v]      = (credit_d[v] == depth_q[v]);
      status_d[v]     = (state_d[v] != ST_IDLE);
      rst_nearly_s[v] = (rst_depth_s[v] <= ONE_C);
      if (OVC_ALLOC_MODE != 0) begin
        avail_d[v]     = (state_d[v] == ST_IDLE) && !full_d[v];
        rst_avail_s[v] = (rst_depth_s[v] != ZERO_C);
      end else begin
        avail_d[v]     = (state_d[v] == ST_IDLE) && !nearly_d[v];
        rst_avail_s[v] = !rst_nearly_s[v];
      end
    end
  end

  // State and registered status; reset reloads depth from the neighbour every cycle it is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q  <= rst_depth_s;
      credit_q <= rst_depth_s;
      err_q    <= '0;
      full_q   <= '0;
      nearly_q <= rst_nearly_s;
      empty_q  <= '1;
      status_q <= '0;
      avail_q  <= rst_avail_s;
      for (int v = 0; v < V; v++) begin
        state_q[v] <= ST_IDLE;
      end
    end else begin
      depth_q  <= depth_q;
      credit_q <= credit_d;
      err_q    <= err_d;
      full_q   <= full_d;
      nearly_q <= nearly_d;
      empty_q  <= empty_d;
      status_q <= status_d;
      avail_q  <= avail_d;
      for (int v = 0; v < V; v++) begin
        state_q[v] <= state_d[v];
      end
    end
  end

  assign bus.ovc_credit      = credit_q;
  assign bus.ovc_full        = full_q;
  assign bus.ovc_nearly_full = nearly_q;
  assign bus.ovc_empty       = empty_q;
  assign bus.ovc_status      = status_q;
  assign bus.ovc_avalable    = avail_q;
  assign bus.credit_err      = err_q;

endmodule

// File: tb/tb_ovc_credit_status_tracker.sv
// Directed table-driven bench for ovc_credit_status_tracker (V=4, B=4, LB=16, mode 0).
module tb_ovc_credit_status_tracker;

  localparam int V  = 4;
  localparam int CW = 5;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  ovc_credit_status_tracker_if #(.V(V), .CREDITw(CW)) bus ();

  ovc_credit_status_tracker #(.V(V), .B(4), .LB(16), .OVC_ALLOC_MODE(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fl = {full, nearly_full, empty, status, avalable, credit_err} for the selected VC
  typedef struct packed {
    logic       rst;
    logic [1:0] vc;
    logic       ci;
    logic       sd;
    logic       al;
    logic       rl;
    logic       ren;
    logic [4:0] cr;
    logic [5:0] fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] vc, input logic ci,
                              input logic sd, input logic al, input logic rl,
                              input logic ren, input logic [4:0] cr, input logic [5:0] fl);
    vec_t r;
    r.rst = rst; r.vc = vc; r.ci = ci; r.sd = sd; r.al = al; r.rl = rl;
    r.ren = ren; r.cr = cr; r.fl = fl;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.credit_release_en    = 4'hF;
    bus.credit_in            = 4'h0;
    bus.buff_space_decreased = 4'h0;
    bus.ovc_is_allocated     = 4'h0;
    bus.ovc_is_released      = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
  endtask

  function automatic logic [10:0] vc_view(input int vc);
    return {bus.ovc_credit[vc*CW +: CW], bus.ovc_full[vc], bus.ovc_nearly_full[vc],
            bus.ovc_empty[vc], bus.ovc_status[vc], bus.ovc_avalable[vc], bus.credit_err[vc]};
  endfunction

  task automatic check_reset_state(input string name);
    check({name, "_credit"}, 64'(bus.ovc_credit), 64'({5'd16, 5'd8, 5'd2, 5'd4}));
    check({name, "_flags"},
          64'({bus.ovc_full, bus.ovc_nearly_full, bus.ovc_empty, bus.ovc_status,
               bus.ovc_avalable, bus.credit_err}),
          64'({4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0}));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    bus.credit_init_val = {5'd20, 5'd8, 5'd2, 5'd0};
    idle_inputs();
    reset = 1'b1;

    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  6'b001100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  6'b000100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2,  6'b000100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  6'b010100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  6'b110100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  6'b010100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  6'b000100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  6'b000100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  6'b001100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  6'b001010));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  6'b001100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  6'b001100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  6'b001010));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2,  6'b001100));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1,  6'b010100));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  6'b110100));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  6'b110100));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  6'b110101));
    vecs.push_back(mk(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1,  6'b010101));
    vecs.push_back(mk(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  6'b001011));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  6'b000010));
    vecs.push_back(mk(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  6'b000010));
    vecs.push_back(mk(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  6'b001010));
    vecs.push_back(mk(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  6'b001011));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  6'b001011));
    vecs.push_back(mk(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd16, 6'b001011));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  6'b001100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  6'b000100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2,  6'b000100));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  6'b010100));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  6'b001010));

    step();
    reset = 1'b1;
    step();
    check_reset_state("in_reset");
    step();
    check_reset_state("after_reset");

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      bus.credit_release_en[vecs[i].vc]    = vecs[i].ren;
      bus.credit_in[vecs[i].vc]            = vecs[i].ci;
      bus.buff_space_decreased[vecs[i].vc] = vecs[i].sd;
      bus.ovc_is_allocated[vecs[i].vc]     = vecs[i].al;
      bus.ovc_is_released[vecs[i].vc]      = vecs[i].rl;
      step();
      check($sformatf("vec%0d_vc%0d", i, vecs[i].vc), 64'(vc_view(int'(vecs[i].vc))),
            64'({vecs[i].cr, vecs[i].fl}));
    end

    check_reset_state("midpkt_reset");

    // Send with no credit left on VC1: holds at zero and flags an error.
    bus.buff_space_decreased[1] = 1'b1; step();
    bus.buff_space_decreased[1] = 1'b1; step();
    bus.buff_space_decreased[1] = 1'b1; step();
    check("underflow_vc1", 64'(vc_view(1)), 64'({5'd0, 6'b110001}));
    check("err_isolation", 64'(bus.credit_err), 64'(4'b0010));

    // Drain-mode release with all credits home goes straight to IDLE.
    bus.ovc_is_allocated[2] = 1'b1; step();
    check("alloc_vc2", 64'(vc_view(2)), 64'({5'd8, 6'b001100}));
    bus.credit_release_en[2] = 1'b0;
    bus.ovc_is_released[2]   = 1'b1; step();
    check("drain_skip_vc2", 64'(vc_view(2)), 64'({5'd8, 6'b001010}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
